// File: rtl/result_unloader_if.sv
// Nibble link between the result unloader and the chip output pins.
// The master presents data/ctrl with valid; the slave answers with ready.
interface result_unloader_if;
    logic [3:0] data_out;
    logic       ctrl_out;
    logic       valid_out;
    logic       ready_in;

    modport master (output data_out, ctrl_out, valid_out, input  ready_in);
    modport slave  (input  data_out, ctrl_out, valid_out, output ready_in);
endinterface

// File: rtl/result_unloader.sv
// Snapshots a result matrix and streams it on the nibble link:
// an R/C header, then the elements row-major, least-significant nibble first.
module result_unloader #(
    parameter int ELEM_W  = 12,
    parameter int MAX_DIM = 2
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              start,
    input  logic [3:0]                        R_in,
    input  logic [3:0]                        C_in,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] res_flat,
    result_unloader_if.master                 link,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int NPE    = ELEM_W / 4;
    localparam int N_NIB  = MAX_DIM * MAX_DIM * NPE;
    localparam int NIB_W  = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int ADDR_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [3:0]       MAX_D4   = 4'(MAX_DIM);
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NPE - 1);

    typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, DATA, FIN} state_e;

    state_e           state_q, state_d;
    logic [3:0]       r_q, r_d, c_q, c_d;
    logic [3:0]       row_q, row_d, col_q, col_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic [3:0]       data_q, data_d;
    logic             ctrl_q, ctrl_d, valid_q, valid_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    // Snapshot stored as a flat nibble array: nibble n of element e lives at e*NPE+n.
    logic [3:0]       buf_q [N_NIB];
    logic             buf_load;

    logic xfer, dims_ok, last_nib, last_col, last_row;

    function automatic logic [ADDR_W-1:0] nib_addr(input logic [3:0]       row,
                                                   input logic [3:0]       col,
                                                   input logic [NIB_W-1:0] nib);
        return ADDR_W'((int'(row) * MAX_DIM + int'(col)) * NPE + int'(nib));
    endfunction

    assign xfer     = valid_q && link.ready_in;
    assign dims_ok  = (R_in != 4'd0) && (R_in <= MAX_D4) && (C_in != 4'd0) && (C_in <= MAX_D4);
    assign last_nib = (nib_q == NIB_LAST);
    assign last_col = (col_q == c_q - 4'd1);
    assign last_row = (row_q == r_q - 4'd1);

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path leaves a latch behind.
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        row_d    = row_q;
        col_d    = col_q;
        nib_d    = nib_q;
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        buf_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        buf_load = 1'b1;
                        r_d      = R_in;
                        c_d      = C_in;
                        state_d  = HDR_R;
                        valid_d  = 1'b1;
                        ctrl_d   = 1'b1;
                        data_d   = R_in;
                        busy_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HDR_R: begin
                if (xfer) begin
                    state_d = HDR_C;
                    data_d  = c_q;
                end
            end
            HDR_C: begin
                if (xfer) begin
                    state_d = DATA;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    nib_d   = '0;
                    ctrl_d  = 1'b0;
                    data_d  = buf_q[nib_addr(4'd0, 4'd0, '0)];
                end
            end
            DATA: begin
                if (xfer) begin
                    if (last_nib && last_col && last_row) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        data_d  = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        // Odometer: nibble, then column, then row; strides stay MAX_DIM wide.
                        nib_d = last_nib ? '0 : nib_q + 1'b1;
                        if (last_nib) begin
                            col_d = last_col ? 4'd0 : col_q + 4'd1;
                            if (last_col) row_d = row_q + 4'd1;
                        end
                        data_d = buf_q[nib_addr(row_d, col_d, nib_d)];
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            c_q     <= 4'd0;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            nib_q   <= '0;
            data_q  <= 4'd0;
            ctrl_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            row_q   <= row_d;
            col_q   <= col_d;
            nib_q   <= nib_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the snapshot memory has no reset; it is only read after a load has filled it.
    always_ff @(posedge CLK) begin
        if (buf_load) begin
            for (int i = 0; i < N_NIB; i++) buf_q[i] <= res_flat[i*4 +: 4];
        end
    end

    assign link.data_out  = data_q;
    assign link.ctrl_out  = ctrl_q;
    assign link.valid_out = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule
